// File: rtl/ram_fifo_ctrl.sv
// rtl/ram_fifo_ctrl.sv - FIFO controller over a single-port RAM with a registered output word
module ram_fifo_ctrl #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty,
    output logic             ram_wr_en,
    output logic [AW-1:0]    ram_addr,
    output logic [WIDTH-1:0] ram_wdata,
    input  logic [WIDTH-1:0] ram_rdata
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READ    = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    state_t        state;
    state_t        next_state;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          fill;
    logic          wr_fire;

    // Refill the output register whenever it is free or being drained this cycle;
    // the single RAM port is then reserved for the read, so writes wait.
    assign fill      = (state == IDLE) && (count != '0) && (!out_valid || out_ready);
    assign in_ready  = rst_n && (state == IDLE) && (count < FULL_COUNT) && !fill;
    assign wr_fire   = in_valid && in_ready;
    assign ram_wr_en = wr_fire;
    assign ram_addr  = (state == IDLE) ? wr_ptr : rd_ptr;
    assign ram_wdata = in_data;
    assign full      = (count == FULL_COUNT);
    assign empty     = (count == '0);

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (fill) next_state = READ;
            READ:    next_state = CAPTURE;
            CAPTURE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            state <= next_state;
            if (wr_fire) begin
                wr_ptr <= wr_ptr + AW'(1);
                count  <= count + CW'(1);
            end
            // Writes only happen in IDLE, so the count never moves both ways at once.
            if (state == CAPTURE) begin
                out_data  <= ram_rdata;
                out_valid <= 1'b1;
                rd_ptr    <= rd_ptr + AW'(1);
                count     <= count - CW'(1);
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// tb/tb_ram_fifo_ctrl.sv - directed vector bench for ram_fifo_ctrl with combinational and registered RAMs
module tb_ram_fifo_ctrl;
    localparam int DEPTH = 8;
    localparam int WIDTH = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, in_valid, out_ready;
    logic [7:0] in_data;

    logic       a_in_ready, a_out_valid, a_full, a_empty, a_wr_en;
    logic [7:0] a_out_data, a_wdata, a_rdata;
    logic [3:0] a_count;
    logic [2:0] a_addr;
    logic       b_in_ready, b_out_valid, b_full, b_empty, b_wr_en;
    logic [7:0] b_out_data, b_wdata, b_rdata;
    logic [3:0] b_count;
    logic [2:0] b_addr;

    logic [7:0] mem_a [DEPTH];
    logic [7:0] mem_b [DEPTH];

    ram_fifo_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data), .count(a_count),
        .full(a_full), .empty(a_empty), .ram_wr_en(a_wr_en), .ram_addr(a_addr),
        .ram_wdata(a_wdata), .ram_rdata(a_rdata)
    );

    ram_fifo_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data), .count(b_count),
        .full(b_full), .empty(b_empty), .ram_wr_en(b_wr_en), .ram_addr(b_addr),
        .ram_wdata(b_wdata), .ram_rdata(b_rdata)
    );

    // dut_a sees a combinational-read RAM, dut_b a one-cycle registered-read RAM
    assign a_rdata = mem_a[a_addr];
    always @(posedge clk) begin
        if (a_wr_en) mem_a[a_addr] <= a_wdata;
        if (b_wr_en) mem_b[b_addr] <= b_wdata;
        b_rdata <= mem_b[b_addr];
    end

    int vecs = 0;
    int errs = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       rst_n;
        logic       in_valid;
        logic [7:0] in_data;
        logic       out_ready;
        logic       ir;
        logic       we;
        logic [2:0] ad;
        logic       ov;
        logic [7:0] od;
        logic [3:0] cnt;
        logic       em;
        logic       fu;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic iv, input logic [7:0] d, input logic orr,
                                input logic ir, input logic we, input logic [2:0] ad, input logic ov,
                                input logic [7:0] od, input logic [3:0] c, input logic em, input logic fu);
        vec_t v;
        v.rst_n = r; v.in_valid = iv; v.in_data = d; v.out_ready = orr;
        v.ir = ir; v.we = we; v.ad = ad; v.ov = ov; v.od = od; v.cnt = c; v.em = em; v.fu = fu;
        return v;
    endfunction

    vec_t tbl [13];

    task automatic write_word(input logic [7:0] d);
        logic ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int k = 0; k < 30 && !ok; k++) begin
            @(negedge clk);
            ok = a_in_ready;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk($sformatf("write %0h accepted", d), ok, 1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = 8'h00;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] q [$];
        logic [7:0] e;
        logic [7:0] nxt;
        logic       acc, seen;
        int         got, pushed;

        //            rst iv  data   or | ir  we  ad ov  od     cnt em  fu
        tbl[0]  = mk(0, 1, 8'h00, 0,  0, 0, 0, 0, 8'h00, 0, 1, 0);
        tbl[1]  = mk(1, 1, 8'h8A, 0,  1, 1, 0, 0, 8'h00, 0, 1, 0);
        tbl[2]  = mk(1, 1, 8'h55, 0,  0, 0, 1, 0, 8'h00, 1, 0, 0);
        tbl[3]  = mk(1, 1, 8'h55, 0,  0, 0, 0, 0, 8'h00, 1, 0, 0);
        tbl[4]  = mk(1, 0, 8'h55, 0,  0, 0, 0, 0, 8'h00, 1, 0, 0);
        tbl[5]  = mk(1, 0, 8'h00, 0,  1, 0, 1, 1, 8'h8A, 0, 1, 0);
        tbl[6]  = mk(1, 0, 8'h00, 1,  1, 0, 1, 1, 8'h8A, 0, 1, 0);
        tbl[7]  = mk(1, 0, 8'h00, 0,  1, 0, 1, 0, 8'h8A, 0, 1, 0);
        tbl[8]  = mk(1, 1, 8'h3C, 0,  1, 1, 1, 0, 8'h8A, 0, 1, 0);
        tbl[9]  = mk(1, 0, 8'h00, 0,  0, 0, 2, 0, 8'h8A, 1, 0, 0);
        tbl[10] = mk(1, 0, 8'h00, 0,  0, 0, 1, 0, 8'h8A, 1, 0, 0);
        tbl[11] = mk(1, 0, 8'h00, 0,  0, 0, 1, 0, 8'h8A, 1, 0, 0);
        tbl[12] = mk(1, 0, 8'h00, 0,  1, 0, 2, 1, 8'h3C, 0, 1, 0);

        do_reset();
        for (int i = 0; i < 13; i++) begin
            rst_n = tbl[i].rst_n; in_valid = tbl[i].in_valid;
            in_data = tbl[i].in_data; out_ready = tbl[i].out_ready;
            @(negedge clk);
            chk($sformatf("v%0d in_ready", i), a_in_ready, tbl[i].ir);
            chk($sformatf("v%0d ram_wr_en", i), a_wr_en, tbl[i].we);
            chk($sformatf("v%0d ram_addr", i), a_addr, tbl[i].ad);
            chk($sformatf("v%0d out_valid", i), a_out_valid, tbl[i].ov);
            chk($sformatf("v%0d out_data", i), a_out_data, tbl[i].od);
            chk($sformatf("v%0d count", i), a_count, tbl[i].cnt);
            chk($sformatf("v%0d empty/full", i), {a_empty, a_full}, {tbl[i].em, tbl[i].fu});
            chk($sformatf("v%0d reg-ram out", i), {b_out_valid, b_out_data}, {tbl[i].ov, tbl[i].od});
            if (tbl[i].we) chk($sformatf("v%0d ram_wdata", i), a_wdata, tbl[i].in_data);
            @(posedge clk); #1;
        end

        // Fill to full with the sink stalled, then drain in order
        do_reset();
        for (int i = 0; i < 9; i++) write_word(8'h8A + 8'(i));
        @(negedge clk);
        chk("full flag", a_full, 1);
        chk("full in_ready", a_in_ready, 0);
        chk("full count", a_count, 8);
        chk("prefetched word", {a_out_valid, a_out_data}, {1'b1, 8'h8A});
        chk("reg-ram prefetched", {b_out_valid, b_out_data, b_count}, {1'b1, 8'h8A, 4'd8});
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = 8'hEE; acc = 1'b0;
        repeat (4) begin
            @(negedge clk);
            acc = acc | a_wr_en | a_in_ready | b_wr_en;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("10th offer stalled", acc, 0);
        out_ready = 1'b1; got = 0;
        for (int k = 0; k < 100 && got < 9; k++) begin
            @(negedge clk);
            if (a_out_valid) begin
                chk($sformatf("drain word %0d", got), a_out_data, 8'h8A + 8'(got));
                chk($sformatf("drain reg-ram %0d", got), {b_out_valid, b_out_data}, {1'b1, 8'h8A + 8'(got)});
                got++;
            end
            @(posedge clk); #1;
        end
        chk("drained words", got, 9);
        @(negedge clk);
        chk("after drain empty/count", {a_empty, a_count}, {1'b1, 4'd0});
        chk("after drain out_valid", a_out_valid, 0);
        chk("wr_ptr wrapped", a_addr, 1);
        @(posedge clk); #1;
        write_word(8'h5A);
        got = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (!a_wr_en && a_addr == 3'd1 && a_count == 4'd1) got++;
            if (a_out_valid) begin
                chk("post-wrap word", {a_out_data, b_out_data}, {8'h5A, 8'h5A});
                k = 10;
            end
            @(posedge clk); #1;
        end
        chk("rd_ptr wrapped read cycles", got, 2);

        // Continuous source and sink
        do_reset();
        out_ready = 1'b1; nxt = 8'h10; pushed = 0;
        for (int c = 0; c < 80; c++) begin
            in_valid = (c < 60);
            in_data  = nxt;
            @(negedge clk);
            acc = in_valid && a_in_ready;
            if (acc) q.push_back(nxt);
            if (a_out_valid) begin
                if (q.size() == 0) chk("stream extra word", 1, 0);
                else begin
                    e = q.pop_front();
                    chk("stream order", a_out_data, e);
                    chk("stream reg-ram", {b_out_valid, b_out_data}, {1'b1, e});
                end
            end
            chk($sformatf("stream wr_en c%0d", c), a_wr_en, acc);
            @(posedge clk); #1;
            if (acc) begin nxt = nxt + 8'd1; pushed++; end
        end
        chk("stream all delivered", q.size(), 0);
        chk("stream progress", (pushed >= 12), 1);

        // Reset during CAPTURE with three words stored
        do_reset();
        for (int i = 0; i < 4; i++) write_word(8'hC0 + 8'(i));
        @(negedge clk);
        chk("pre-abort count", a_count, 3);
        chk("pre-abort out", {a_out_valid, a_out_data}, {1'b1, 8'hC0});
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("abort fill addr", a_addr, 4);
        @(posedge clk); #1;
        @(negedge clk);
        chk("abort READ addr", {a_wr_en, a_addr}, {1'b0, 3'd1});
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort CAPTURE state", {a_count, a_out_valid, a_addr}, {4'd3, 1'b0, 3'd1});
        chk("reset forces in_ready", a_in_ready, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post-abort count", {a_count, b_count}, 8'h00);
        chk("post-abort out_valid", {a_out_valid, b_out_valid}, 0);
        chk("post-abort flags", {a_empty, a_full, a_addr, a_in_ready}, {1'b1, 1'b0, 3'd0, 1'b1});
        chk("post-abort out_data", a_out_data, 0);
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            seen = seen | a_out_valid | b_out_valid;
        end
        chk("old data never appears", seen, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
